ref_buf_loader: RTL

//   Writer side of the intra reference-pixel buffer. Accepts reconstructed neighbour pixels
//   as a valid/ready stream and fills four banks: TOP, TOPa, LEFT, LEFTa (N_REF pixels each).

---
 rtl/ref_pkg.sv | 35 +++
 rtl/ref_bank.sv | 38 +++
 rtl/ref_buf_loader.sv | 117 +++++++++++
 3 files changed

// File: rtl/ref_pkg.sv
// Shared constants for the intra reference-pixel buffer loader.
// Default geometry, FSM state encoding and the fill pixel for unavailable neighbours.
package ref_pkg;

    localparam int PIX_W_DEF = 8;
    localparam int N_REF_DEF = 8;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_LD_TOP   = 3'd1;
    localparam logic [2:0] ST_LD_TOPA  = 3'd2;
    localparam logic [2:0] ST_LD_LEFT  = 3'd3;
    localparam logic [2:0] ST_LD_LEFTA = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    typedef enum logic [2:0] {
        IDLE     = ST_IDLE,
        LD_TOP   = ST_LD_TOP,
        LD_TOPA  = ST_LD_TOPA,
        LD_LEFT  = ST_LD_LEFT,
        LD_LEFTA = ST_LD_LEFTA,
        DONE     = ST_DONE
    } state_t;

    // Mid-scale pixel stands in for neighbours that do not exist.
    function automatic int def_pix(input int w);
        return 1 << (w - 1);
    endfunction

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam logic [PIX_W_DEF-1:0] DEF_PIX = PIX_W_DEF'(def_pix(PIX_W_DEF));

endpackage

// File: rtl/ref_bank.sv
// N_REF x PIX_W register file exposed as a flat bus; FILL loads the default pixel everywhere.
// Latency: write visible on BUS the cycle after WE/FILL. No backpressure (always writable).
// FILL has priority over WE.
module ref_bank
    import ref_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int N_REF = N_REF_DEF
) (
    input  logic                       CLK,
    input  logic                       RST,
    input  logic                       WE,
    input  logic [idx_w(N_REF)-1:0]    WIDX,
    input  logic [PIX_W-1:0]           WDATA,
    input  logic                       FILL,
    output logic [N_REF*PIX_W-1:0]     BUS
);

    localparam logic [PIX_W-1:0] FILL_PIX = PIX_W'(def_pix(PIX_W));

    logic [PIX_W-1:0] mem [N_REF];

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_REF; i++) mem[i] <= '0;
        end else if (FILL) begin
            for (int i = 0; i < N_REF; i++) mem[i] <= FILL_PIX;
        end else if (WE) begin
            mem[WIDX] <= WDATA;
        end
    end

    always_comb begin
        BUS = '0;
        for (int i = 0; i < N_REF; i++) BUS[i*PIX_W +: PIX_W] = mem[i];
    end

endmodule

// File: rtl/ref_buf_loader.sv
// Fills TOP/TOPa/LEFT/LEFTa reference banks from a pixel stream, default-filling missing sides.
// Latency: REF_VALID rises the cycle after the last accepted pixel (START+1 if nothing to load).
// Backpressure: PIX_READY is a pure state decode; PIX_VALID bubbles simply stall the load.
module ref_buf_loader
    import ref_pkg::*;
#(
    parameter int PIX_W = PIX_W_DEF,
    parameter int N_REF = N_REF_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   START,
    input  logic                   AVAIL_TOP,
    input  logic                   AVAIL_LEFT,
    input  logic                   PIX_VALID,
    input  logic [PIX_W-1:0]       PIX_DATA,
    output logic                   PIX_READY,
    output logic [N_REF*PIX_W-1:0] REF_TOP_BUS,
    output logic [N_REF*PIX_W-1:0] REF_TOPA_BUS,
    output logic [N_REF*PIX_W-1:0] REF_LEFT_BUS,
    output logic [N_REF*PIX_W-1:0] REF_LEFTA_BUS,
    output logic                   REF_VALID,
    output logic                   BUSY
);

    localparam int               IDX_W    = idx_w(N_REF);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_REF - 1);

    state_t           state, state_nxt;
    logic [IDX_W-1:0] idx, idx_nxt;
    logic             avail_left_q;
    logic             start_ok;
    logic             xfer;
    logic             idx_last;
    logic [3:0]       bank_we;
    logic             fill_top;
    logic             fill_left;

    assign BUSY      = (state == LD_TOP) || (state == LD_TOPA) ||
                       (state == LD_LEFT) || (state == LD_LEFTA);
    assign PIX_READY = BUSY;
    assign REF_VALID = (state == DONE);

    assign start_ok = START && ((state == IDLE) || (state == DONE));
    assign xfer     = PIX_VALID && PIX_READY;
    assign idx_last = (idx == IDX_LAST);

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        bank_we   = 4'b0000;
        fill_top  = 1'b0;
        fill_left = 1'b0;
        if (start_ok) begin
            idx_nxt   = '0;
            fill_top  = !AVAIL_TOP;
            fill_left = !AVAIL_LEFT;
            if (AVAIL_TOP)       state_nxt = LD_TOP;
            else if (AVAIL_LEFT) state_nxt = LD_LEFT;
            else                 state_nxt = DONE;
        end else if (xfer) begin
            idx_nxt = idx_last ? '0 : idx + IDX_W'(1);
            case (state)
                LD_TOP: begin
                    bank_we[0] = 1'b1;
                    if (idx_last) state_nxt = LD_TOPA;
                end
                LD_TOPA: begin
                    bank_we[1] = 1'b1;
                    if (idx_last) state_nxt = avail_left_q ? LD_LEFT : DONE;
                end
                LD_LEFT: begin
                    bank_we[2] = 1'b1;
                    if (idx_last) state_nxt = LD_LEFTA;
                end
                LD_LEFTA: begin
                    bank_we[3] = 1'b1;
                    if (idx_last) state_nxt = DONE;
                end
                default: state_nxt = state;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= IDLE;
            idx          <= '0;
            avail_left_q <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            if (start_ok) avail_left_q <= AVAIL_LEFT;
        end
    end

    ref_bank #(.PIX_W(PIX_W), .N_REF(N_REF)) u_top (
        .CLK(CLK), .RST(RST), .WE(bank_we[0]), .WIDX(idx), .WDATA(PIX_DATA),
        .FILL(fill_top), .BUS(REF_TOP_BUS)
    );

    ref_bank #(.PIX_W(PIX_W), .N_REF(N_REF)) u_topa (
        .CLK(CLK), .RST(RST), .WE(bank_we[1]), .WIDX(idx), .WDATA(PIX_DATA),
        .FILL(fill_top), .BUS(REF_TOPA_BUS)
    );

    ref_bank #(.PIX_W(PIX_W), .N_REF(N_REF)) u_left (
        .CLK(CLK), .RST(RST), .WE(bank_we[2]), .WIDX(idx), .WDATA(PIX_DATA),
        .FILL(fill_left), .BUS(REF_LEFT_BUS)
    );

    ref_bank #(.PIX_W(PIX_W), .N_REF(N_REF)) u_lefta (
        .CLK(CLK), .RST(RST), .WE(bank_we[3]), .WIDX(idx), .WDATA(PIX_DATA),
        .FILL(fill_left), .BUS(REF_LEFTA_BUS)
    );

endmodule
